// File: rtl/video_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen_pkg
// Description : Shared types, defaults and config check for video_timing_gen.
// Revision    : 1.0 - initial release
// ============================================================================
package video_timing_gen_pkg;

    localparam int C_H_W   = 12;
    localparam int C_V_W   = 11;
    localparam int C_CFG_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [C_CFG_W-1:0] h_low;
        logic [C_CFG_W-1:0] h_bp;
        logic [C_CFG_W-1:0] h_active;
        logic [C_CFG_W-1:0] v_low;
        logic [C_CFG_W-1:0] v_bp;
        logic [C_CFG_W-1:0] v_active;
    } cfg_t;

    // Totals are summed at 32 bits so three full-scale fields cannot alias
    // back under the limit.
    function automatic logic cfg_valid(input cfg_t c, input int hw, input int vw);
        logic [31:0] h_tot;
        logic [31:0] v_tot;
        logic [31:0] h_max;
        logic [31:0] v_max;
        h_tot = 32'(c.h_low) + 32'(c.h_bp) + 32'(c.h_active);
        v_tot = 32'(c.v_low) + 32'(c.v_bp) + 32'(c.v_active);
        h_max = (32'd1 << hw) - 32'd1;
        v_max = (32'd1 << vw) - 32'd1;
        return (c.h_low != '0) && (c.h_active != '0) &&
               (c.v_low != '0) && (c.v_active != '0) &&
               (h_tot <= h_max) && (v_tot <= v_max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen_if
// Description : Config inputs and raster outputs of the video timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_gen_if
    import video_timing_gen_pkg::*;
#(
    parameter int H_W = C_H_W,
    parameter int V_W = C_V_W
);

    logic           enable;
    logic [H_W-1:0] h_low;
    logic [H_W-1:0] h_bp;
    logic [H_W-1:0] h_active;
    logic [V_W-1:0] v_low;
    logic [V_W-1:0] v_bp;
    logic [V_W-1:0] v_active;

    logic           vs_out;
    logic           hs_out;
    logic           de_out;
    logic [H_W-1:0] x_out;
    logic [V_W-1:0] y_out;
    logic           frame_start;
    logic           cfg_err;

    modport master (
        output enable, h_low, h_bp, h_active, v_low, v_bp, v_active,
        input  vs_out, hs_out, de_out, x_out, y_out, frame_start, cfg_err
    );

    modport slave (
        input  enable, h_low, h_bp, h_active, v_low, v_bp, v_active,
        output vs_out, hs_out, de_out, x_out, y_out, frame_start, cfg_err
    );

endinterface
`default_nettype wire

// File: rtl/video_timing_gen_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : axis_counter
// Description : Wrapping pixel/line counter with low / back-porch / active
//               region compares.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_counter #(
    parameter int W = 12
) (
    input  wire          clk,
    input  wire          rst_b,
    input  wire          i_clr,
    input  wire          i_inc,
    input  wire  [W-1:0] i_lo,
    input  wire  [W-1:0] i_bp,
    input  wire  [W-1:0] i_act,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap,
    output logic         o_in_mid,
    output logic         o_in_act
);

    logic [W-1:0] r_cnt;
    logic [W:0]   w_act_start;
    logic [W:0]   w_last;

    assign w_act_start = {1'b0, i_lo} + {1'b0, i_bp};
    assign w_last      = w_act_start + {1'b0, i_act} - (W+1)'(1);

    assign o_cnt    = r_cnt;
    assign o_wrap   = ({1'b0, r_cnt} == w_last);
    assign o_in_mid = (r_cnt >= i_lo);
    assign o_in_act = ({1'b0, r_cnt} >= w_act_start);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= o_wrap ? '0 : r_cnt + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Programmable vs/hs/de raster generator with frame-boundary
//               config latching and registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_W = C_H_W,
    parameter int V_W = C_V_W
) (
    input wire          clk,
    input wire          rst_b,
    video_timing_gen_if.slave bus
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_latch;
    logic           w_set_err;
    cfg_t           w_cfg_in;
    logic           w_cfg_ok;

    logic [H_W-1:0] r_h_low, r_h_bp, r_h_active;
    logic [V_W-1:0] r_v_low, r_v_bp, r_v_active;

    logic [H_W-1:0] w_h_cnt;
    logic [V_W-1:0] w_v_cnt;
    logic           w_h_wrap, w_h_in_mid, w_h_in_act;
    logic           w_v_wrap, w_v_in_mid, w_v_in_act;
    logic           w_frame_end;
    logic           w_frame_first;
    logic           w_idle;
    logic [H_W-1:0] w_x;
    logic [V_W-1:0] w_y;

    logic           r_vs, r_hs, r_de, r_fs, r_cfg_err;
    logic [H_W-1:0] r_x;
    logic [V_W-1:0] r_y;

    always_comb begin
        w_cfg_in          = '0;
        w_cfg_in.h_low    = C_CFG_W'(bus.h_low);
        w_cfg_in.h_bp     = C_CFG_W'(bus.h_bp);
        w_cfg_in.h_active = C_CFG_W'(bus.h_active);
        w_cfg_in.v_low    = C_CFG_W'(bus.v_low);
        w_cfg_in.v_bp     = C_CFG_W'(bus.v_bp);
        w_cfg_in.v_active = C_CFG_W'(bus.v_active);
    end

    assign w_cfg_ok = cfg_valid(w_cfg_in, H_W, V_W);
    assign w_idle   = (r_state == ST_IDLE);

    axis_counter #(.W(H_W)) u_h_cnt (
        .clk      (clk),
        .rst_b    (rst_b),
        .i_clr    (w_idle),
        .i_inc    (1'b1),
        .i_lo     (r_h_low),
        .i_bp     (r_h_bp),
        .i_act    (r_h_active),
        .o_cnt    (w_h_cnt),
        .o_wrap   (w_h_wrap),
        .o_in_mid (w_h_in_mid),
        .o_in_act (w_h_in_act)
    );

    axis_counter #(.W(V_W)) u_v_cnt (
        .clk      (clk),
        .rst_b    (rst_b),
        .i_clr    (w_idle),
        .i_inc    (w_h_wrap),
        .i_lo     (r_v_low),
        .i_bp     (r_v_bp),
        .i_act    (r_v_active),
        .o_cnt    (w_v_cnt),
        .o_wrap   (w_v_wrap),
        .o_in_mid (w_v_in_mid),
        .o_in_act (w_v_in_act)
    );

    assign w_frame_end   = (r_state == ST_RUN) && w_h_wrap && w_v_wrap;
    assign w_frame_first = (w_h_cnt == '0) && (w_v_cnt == '0);
    assign w_x           = w_h_cnt - r_h_low - r_h_bp;
    assign w_y           = w_v_cnt - r_v_low - r_v_bp;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Config is only ever examined at a frame boundary or while idle.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.enable && w_cfg_ok) begin
                    w_state_nxt = ST_RUN;
                    w_latch     = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_frame_end) begin
                    if (bus.enable && w_cfg_ok) begin
                        w_latch = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_set_err   = bus.enable && !w_cfg_ok;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_h_low    <= '0;
            r_h_bp     <= '0;
            r_h_active <= '0;
            r_v_low    <= '0;
            r_v_bp     <= '0;
            r_v_active <= '0;
        end else if (w_latch) begin
            r_h_low    <= bus.h_low;
            r_h_bp     <= bus.h_bp;
            r_h_active <= bus.h_active;
            r_v_low    <= bus.v_low;
            r_v_bp     <= bus.v_bp;
            r_v_active <= bus.v_active;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_vs <= 1'b0;
            r_hs <= 1'b0;
            r_de <= 1'b0;
            r_x  <= '0;
            r_y  <= '0;
            r_fs <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_vs <= w_v_in_mid;
            r_hs <= w_h_in_mid;
            r_de <= w_v_in_act && w_h_in_act;
            r_x  <= (w_v_in_act && w_h_in_act) ? w_x : '0;
            r_y  <= w_v_in_act ? w_y : '0;
            r_fs <= w_frame_first;
        end else begin
            r_vs <= 1'b0;
            r_hs <= 1'b0;
            r_de <= 1'b0;
            r_x  <= '0;
            r_y  <= '0;
            r_fs <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cfg_err <= 1'b0;
        end else if (w_set_err) begin
            r_cfg_err <= 1'b1;
        end else if ((r_state == ST_RUN) && w_frame_first) begin
            r_cfg_err <= 1'b0;
        end
    end

    assign bus.vs_out      = r_vs;
    assign bus.hs_out      = r_hs;
    assign bus.de_out      = r_de;
    assign bus.x_out       = r_x;
    assign bus.y_out       = r_y;
    assign bus.frame_start = r_fs;
    assign bus.cfg_err     = r_cfg_err;

endmodule
`default_nettype wire
